// File: rtl/pc_ir_unit.sv
// Fetch-side datapath stage: PC, IR and MDR registers, the unified memory address mux,
// IR field decode, and retired-instruction / taken-branch counters.
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        zero,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic        ir_write,
  input  logic        mem_get_data,
  input  logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [31:0] jump_target,
  output logic [31:0] mdr,
  output logic        misaligned,
  output logic [31:0] instr_count,
  output logic [15:0] branch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [15:0] branch_count_q, branch_count_d;

  logic        pc_en;
  logic        branch_taken;
  logic [31:0] pc_sel;
  logic [31:0] jump_target_w;

  assign jump_target_w = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign pc_en         = pc_write | (pc_write_cond & zero);
  // An unconditional write that happens to coincide with a true condition is not a branch.
  assign branch_taken  = pc_write_cond & zero & ~pc_write;

  always_comb begin
    pc_sel = pc_q;
    case (pc_src)
      2'd0:    pc_sel = alu_result;
      2'd1:    pc_sel = alu_out;
      2'd2:    pc_sel = jump_target_w;
      default: pc_sel = pc_q;
    endcase
  end

  always_comb begin
    pc_d           = pc_q;
    ir_d           = ir_q;
    mdr_d          = mdr_q;
    misaligned_d   = misaligned_q;
    instr_count_d  = instr_count_q;
    branch_count_d = branch_count_q;

    if (pc_en) begin
      pc_d = {pc_sel[31:2], 2'b00};
      if (pc_sel[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end
    end
    if (branch_taken && (branch_count_q != 16'hFFFF)) begin
      branch_count_d = branch_count_q + 16'd1;
    end
    if (ir_write) begin
      ir_d          = mem_rdata;
      instr_count_d = instr_count_q + 32'd1;
    end
    if (mem_read) begin
      mdr_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      ir_q           <= 32'd0;
      mdr_q          <= 32'd0;
      misaligned_q   <= 1'b0;
      instr_count_q  <= 32'd0;
      branch_count_q <= 16'd0;
    end else begin
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      mdr_q          <= mdr_d;
      misaligned_q   <= misaligned_d;
      instr_count_q  <= instr_count_d;
      branch_count_q <= branch_count_d;
    end
  end

  // The address uses the pre-edge PC so IF reads the word the IR is about to capture.
  assign mem_addr     = mem_get_data ? alu_out : pc_q;
  assign mem_re       = mem_read;
  assign pc           = pc_q;
  assign ir           = ir_q;
  assign opcode       = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign imm_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign jump_target  = jump_target_w;
  assign mdr          = mdr_q;
  assign misaligned   = misaligned_q;
  assign instr_count  = instr_count_q;
  assign branch_count = branch_count_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed-vector bench for pc_ir_unit: a table of single-cycle steps plus
// hand-written decode and reset sequences.
module tb_pc_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, pc_write_cond, zero;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, alu_out;
  logic        ir_write, mem_get_data, mem_read;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] pc, ir;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext, jump_target, mdr;
  logic        misaligned;
  logic [31:0] instr_count;
  logic [15:0] branch_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_ir_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .zero(zero),
    .pc_src(pc_src), .alu_result(alu_result), .alu_out(alu_out),
    .ir_write(ir_write), .mem_get_data(mem_get_data), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_re(mem_re),
    .pc(pc), .ir(ir), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm_sext(imm_sext), .jump_target(jump_target),
    .mdr(mdr), .misaligned(misaligned), .instr_count(instr_count),
    .branch_count(branch_count)
  );

  typedef struct {
    logic        rst;
    logic        pw;
    logic        pwc;
    logic        z;
    logic [1:0]  src;
    logic [31:0] alu_res;
    logic [31:0] alu_o;
    logic        irw;
    logic        gd;
    logic        mr;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    logic [31:0] exp_mdr;
    logic        exp_mis;
    logic [31:0] exp_ic;
    logic [15:0] exp_bc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; zero = 1'b0;
    pc_src = 2'd0; alu_result = 32'd0; alu_out = 32'd0;
    ir_write = 1'b0; mem_get_data = 1'b0; mem_read = 1'b0; mem_rdata = 32'd0;
  endtask

  initial begin
    //             rst pw pwc z src alu_res        alu_o          irw gd mr rdata          addr           pc             ir             mdr            mis ic     bc
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,32'h0000_0104,32'h0,        1'b1,1'b0,1'b1,32'h2002_0005,32'h0000_0100,32'h0000_0104,32'h2002_0005,32'h2002_0005,1'b0,32'd1,16'd0};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,2'd1,32'h0,        32'h0000_0200,1'b0,1'b0,1'b0,32'h0,        32'h0000_0104,32'h0000_0104,32'h2002_0005,32'h2002_0005,1'b0,32'd1,16'd0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,2'd1,32'h0,        32'h0000_0200,1'b0,1'b0,1'b0,32'h0,        32'h0000_0104,32'h0000_0200,32'h2002_0005,32'h2002_0005,1'b0,32'd1,16'd1};
    vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,2'd0,32'h0000_0300,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h0000_0200,32'h0000_0300,32'h2002_0005,32'h2002_0005,1'b0,32'd1,16'd1};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,2'd3,32'h0000_0555,32'h0000_0777,1'b0,1'b0,1'b0,32'h0,        32'h0000_0300,32'h0000_0300,32'h2002_0005,32'h2002_0005,1'b0,32'd1,16'd1};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,32'h0,        32'h0000_0040,1'b0,1'b1,1'b1,32'hDEAD_BEEF,32'h0000_0040,32'h0000_0300,32'h2002_0005,32'hDEAD_BEEF,1'b0,32'd1,16'd1};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,32'h0,        32'h0000_0040,1'b0,1'b0,1'b0,32'h1234_5678,32'h0000_0300,32'h0000_0300,32'h2002_0005,32'hDEAD_BEEF,1'b0,32'd1,16'd1};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,32'h0000_0107,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h0000_0300,32'h0000_0104,32'h2002_0005,32'hDEAD_BEEF,1'b1,32'd1,16'd1};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,32'h0000_0108,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h0000_0104,32'h0000_0108,32'h2002_0005,32'hDEAD_BEEF,1'b1,32'd1,16'd1};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,32'h0,        32'h0,        1'b1,1'b0,1'b0,32'h0800_0040,32'h0000_0108,32'h0000_0108,32'h0800_0040,32'hDEAD_BEEF,1'b1,32'd2,16'd1};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,2'd1,32'h0,        32'h3000_0000,1'b0,1'b0,1'b0,32'h0,        32'h0000_0108,32'h3000_0000,32'h0800_0040,32'hDEAD_BEEF,1'b1,32'd2,16'd1};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,2'd2,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h3000_0000,32'h3000_0100,32'h0800_0040,32'hDEAD_BEEF,1'b1,32'd2,16'd1};
    vecs[12] = '{1'b1,1'b1,1'b1,1'b1,2'd0,32'h0000_0204,32'h0000_0040,1'b1,1'b1,1'b1,32'hDEAD_BEEF,32'h0000_0040,32'h0000_0100,32'h0,        32'h0,        1'b0,32'd0,16'd0};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_pc", pc, 32'h0000_0100);
    chk("reset_ir", ir, 32'h0);
    chk("reset_opcode", {26'd0, opcode}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0000_0100);
    chk("reset_instr_count", instr_count, 32'h0);
    chk("reset_branch_count", {16'd0, branch_count}, 32'h0);
    chk("reset_misaligned", {31'd0, misaligned}, 32'h0);
    chk("reset_jump_target", jump_target, 32'h0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; pc_write = vecs[i].pw; pc_write_cond = vecs[i].pwc;
      zero = vecs[i].z; pc_src = vecs[i].src; alu_result = vecs[i].alu_res;
      alu_out = vecs[i].alu_o; ir_write = vecs[i].irw; mem_get_data = vecs[i].gd;
      mem_read = vecs[i].mr; mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_mem_re", i), {31'd0, mem_re}, {31'd0, vecs[i].mr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_ir", i), ir, vecs[i].exp_ir);
      chk($sformatf("v%0d_mdr", i), mdr, vecs[i].exp_mdr);
      chk($sformatf("v%0d_misaligned", i), {31'd0, misaligned}, {31'd0, vecs[i].exp_mis});
      chk($sformatf("v%0d_instr_count", i), instr_count, vecs[i].exp_ic);
      chk($sformatf("v%0d_branch_count", i), {16'd0, branch_count}, {16'd0, vecs[i].exp_bc});
      $display("vec %0d: pc=%h ir=%h mdr=%h mis=%0d ic=%0d bc=%0d",
               i, pc, ir, mdr, misaligned, instr_count, branch_count);
      if (i == 0) begin
        chk("v0_opcode", {26'd0, opcode}, 32'h8);
        chk("v0_rt", {27'd0, rt}, 32'h2);
        chk("v0_imm_sext", imm_sext, 32'h5);
      end
      if (i == 11) begin
        chk("v11_jump_target", jump_target, 32'h3000_0100);
        chk("v11_opcode", {26'd0, opcode}, 32'h2);
      end
    end

    // Decode of a load word with negative offset, IR latched alone after reset.
    @(negedge clk);
    idle_inputs();
    ir_write = 1'b1;
    mem_rdata = 32'h8C43_FFFC;
    @(posedge clk);
    #1;
    chk("lw_opcode", {26'd0, opcode}, 32'h23);
    chk("lw_rs", {27'd0, rs}, 32'h2);
    chk("lw_rt", {27'd0, rt}, 32'h3);
    chk("lw_rd", {27'd0, rd}, 32'h1F);
    chk("lw_funct", {26'd0, funct}, 32'h3C);
    chk("lw_imm_sext", imm_sext, 32'hFFFF_FFFC);
    chk("lw_jump_target", jump_target, 32'h010F_FFF0);
    chk("lw_pc_held", pc, 32'h0000_0100);
    chk("lw_instr_count", instr_count, 32'd1);
    $display("seq lw: opcode=%h rs=%0d rt=%0d rd=%0d imm=%h", opcode, rs, rt, rd, imm_sext);

    // Two back-to-back taken branches then a hold cycle.
    @(negedge clk);
    idle_inputs();
    pc_write_cond = 1'b1; zero = 1'b1; pc_src = 2'd1; alu_out = 32'h0000_0800;
    @(posedge clk);
    @(negedge clk);
    alu_out = 32'h0000_0A00;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("br2_pc", pc, 32'h0000_0A00);
    chk("br2_branch_count", {16'd0, branch_count}, 32'd2);
    chk("br2_misaligned", {31'd0, misaligned}, 32'h0);
    $display("seq branches: pc=%h bc=%0d", pc, branch_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
